// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16 unsigned shift-add multiply sequencer that borrows the shared ALU_16 adder.
// Latency: start sampled at E0, 16 RUN cycles, done pulses in the cycle after E16, ready again after E17.
// Backpressure: ready=0 while busy; a start seen with ready=0 is dropped (no queueing), flush aborts to IDLE.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start, flush     operation request (taken only when ready=1), synchronous abort (wins over start)
//   op_a, op_b       multiplicand, multiplier
//   ready, done      idle/accepting, one-cycle product-valid pulse
//   product          32-bit result, held until the next completed operation
//   alu_own          operand-mux select: this block drives the shared ALU
//   alu_op/a/b       ALU request (always ADD)
//   alu_result       combinational ALU_16 sum for the current alu_a/alu_b
//
// Optional build macro MUL_EARLY_TERM_EN: finish as soon as no multiplier bits remain.
module alu_mul_seq #(
    parameter int WIDTH = 16,   // only 16 is supported (ALU_16)
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               alu_own,
    output logic [2:0]         alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result
);

    // ADD encoding shared with alu_ops.h
    localparam logic [2:0] ALU_ADD = 3'd0;

    // One-hot so ready/done come straight off a state flop.
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 add_cyc;
    logic                 carry;
    logic [2*WIDTH-1:0]   shifted;

    // An add is issued on every RUN cycle, except (early-term build) once
    // the remaining multiplier bits are all zero.
`ifdef MUL_EARLY_TERM_EN
    assign add_cyc = (state_q == S_RUN) && (mplr_q != '0);
`else
    assign add_cyc = (state_q == S_RUN);
`endif

    assign alu_own = add_cyc;
    assign alu_op  = ALU_ADD;
    assign alu_a   = add_cyc ? hi_q : '0;
    assign alu_b   = (add_cyc && lo_q[0]) ? mcand_q : '0;

    // ALU_16 exposes no carry-out; rebuild it from the operand and sum MSBs.
    assign carry   = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                     ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_result[WIDTH-1]);
    assign shifted = {carry, alu_result, lo_q[WIDTH-1:1]};

    assign ready   = state_q[0];
    assign done    = state_q[2];
    assign product = product_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    lo_d    = op_b;
                    mplr_d  = op_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef MUL_EARLY_TERM_EN
                // Remaining multiplier bits are zero: the partial product sits
                // in the top cnt+16 bits, so right-align it and finish.
                if (mplr_q == '0) begin
                    product_d = {hi_q, lo_q} >> (CNT_W'(WIDTH) - cnt_q);
                    state_d   = S_DONE;
                end else
`endif
                begin
                    hi_d   = shifted[2*WIDTH-1:WIDTH];
                    lo_d   = shifted[WIDTH-1:0];
                    mplr_d = mplr_q >> 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        product_d = shifted;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            product_d = product_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench for alu_mul_seq with a combinational ALU_16 adder model.
// Latency: expected done timing derived from the operand (full or early-terminated run).
// Backpressure: exercises start while busy, flush mid-run and asynchronous reset mid-run.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        ready;
    logic        done;
    logic [31:0] product;
    logic        alu_own;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_prod;

    always #5 clk = ~clk;

    // Shared ALU_16 stand-in: plain 16-bit add, no carry-out.
    assign alu_result = alu_a + alu_b;

    alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flush      (flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .ready      (ready),
        .done       (done),
        .product    (product),
        .alu_own    (alu_own),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef MUL_EARLY_TERM_EN
    function automatic int hib(input logic [15:0] b);
        for (int i = 15; i >= 0; i--) if (b[i]) return i;
        return -1;
    endfunction
    // Negedges from the start edge to the done sample = RUN cycles + 1.
    function automatic int exp_lat(input logic [15:0] b);
        int h;
        h = hib(b);
        if (h < 0) return 2;
        return ((h + 2 > 16) ? 16 : h + 2) + 1;
    endfunction
    function automatic int exp_own(input logic [15:0] b);
        int h;
        h = hib(b);
        if (h < 0) return 0;
        return (h + 1 > 16) ? 16 : h + 1;
    endfunction
`else
    function automatic int exp_lat(input logic [15:0] b);
        return (b === 16'hxxxx) ? 0 : 17;
    endfunction
    function automatic int exp_own(input logic [15:0] b);
        return (b === 16'hxxxx) ? 0 : 16;
    endfunction
`endif

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_prod"}, product, e);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    // One complete multiply: drive, then check latency, ALU ownership,
    // product hold while busy, scoreboard product and return to ready.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input string tag);
        int   n;
        int   own;
        logic held;
        wait_ready(tag);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        exp_q.push_back({16'h0, a} * {16'h0, b});
        @(posedge clk);
        n    = 0;
        own  = 0;
        held = 1'b1;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (alu_own === 1'b1) own++;
            if (done !== 1'b1 && product !== last_prod) held = 1'b0;
        end while (done !== 1'b1 && n < 40);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat(b)));
        chk({tag, "_own"}, 32'(own), 32'(exp_own(b)));
        chk({tag, "_held"}, 32'(held), 32'd1);
        pop_chk(tag);
        last_prod = product;
        @(negedge clk);
        chk({tag, "_rdy_after"}, 32'(ready), 32'd1);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   n;
        int   d1;
        logic held;
        logic seen_done;

        rst       = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        last_prod = '0;
        repeat (2) @(negedge clk);

        chk("rst_ready",   32'(ready),   32'd1);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_product", product,      32'd0);
        chk("rst_own",     32'(alu_own), 32'd0);
        chk("rst_alu_a",   32'(alu_a),   32'd0);
        chk("rst_alu_b",   32'(alu_b),   32'd0);
        chk("rst_alu_op",  32'(alu_op),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_mul(16'h0003, 16'h0005, "m3x5");
        chk("m3x5_const", product, 32'h0000000F);
        run_mul(16'hFFFF, 16'hFFFF, "mffff");
        chk("mffff_const", product, 32'hFFFE0001);
        run_mul(16'h8000, 16'h0002, "m8000");
        chk("m8000_const", product, 32'h00010000);
        run_mul(16'h0000, 16'h1234, "za");
        run_mul(16'h1234, 16'h0000, "zb");
        run_mul(16'h0100, 16'h0003, "et");
        chk("et_const", product, 32'h00000300);
        run_mul(16'hA5A5, 16'h4000, "b14");

        // Back-to-back: start held high; second operands presented while busy.
        wait_ready("b2b");
        op_a  = 16'h00FF;
        op_b  = 16'h0101;
        start = 1'b1;
        exp_q.push_back(32'h00FF * 32'h0101);
        exp_q.push_back(32'hBEEF * 32'hCAFE);
        @(posedge clk);
        @(negedge clk);
        op_a = 16'hBEEF;
        op_b = 16'hCAFE;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_rdy_in_done", 32'(ready), 32'd0);
        pop_chk("b2b1");
        last_prod = product;
        d1   = 0;
        held = 1'b1;
        do begin
            @(negedge clk);
            d1++;
            if (done !== 1'b1 && product !== last_prod) held = 1'b0;
        end while (done !== 1'b1 && d1 < 40);
        start = 1'b0;
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_gap", 32'(d1), 32'(exp_lat(16'hCAFE) + 1));
        chk("b2b_held", 32'(held), 32'd1);
        pop_chk("b2b2");
        last_prod = product;
        repeat (2) @(negedge clk);
        chk("b2b_no_third", 32'(ready), 32'd1);

        // Flush at RUN cycle 7: no done, product unchanged.
        wait_ready("fl");
        op_a  = 16'h1234;
        op_b  = 16'h5678;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk("fl_ready", 32'(ready), 32'd1);
        chk("fl_own", 32'(alu_own), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("fl_no_done", 32'(seen_done), 32'd0);
        chk("fl_product", product, last_prod);
        run_mul(16'h1234, 16'h5678, "post_fl");
        chk("post_fl_const", product, 32'h06260060);

        // Asynchronous reset between edges in the middle of a run.
        wait_ready("ar");
        op_a  = 16'hABCD;
        op_b  = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_product", product,      32'd0);
        chk("ar_ready",   32'(ready),   32'd1);
        chk("ar_done",    32'(done),    32'd0);
        chk("ar_own",     32'(alu_own), 32'd0);
        chk("ar_alu_a",   32'(alu_a),   32'd0);
        chk("ar_alu_b",   32'(alu_b),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_prod = '0;
        @(negedge clk);
        run_mul(16'h8000, 16'h0002, "post_ar");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
